free_list: RTL and testbench
============================

Name: free_list

Overview:
- Physical-register free list for the rename stage; it supplies the new aliases that rename writes into the RAT.
- It is the producer side of the RAT alias write path: it allocates pregs at rename and reclaims stale pregs at commit.
- Implemented as a circular FIFO holding exactly the pregs not mapped by the architectural state.
- Holds a commit-side head pointer so a full pipeline flush restores the free list in one cycle.

Parameters:
- NUM_PREGS, 64: physical registers (from CORE_PKG).
- NUM_AREGS, 32: architectural registers (from CORE_PKG).
- RENAME_WIDTH, 2: alloc lanes per cycle.
- COMMIT_WIDTH, 2: free/commit lanes per cycle.
- Derived: DEPTH = NUM_PREGS-NUM_AREGS; PW = $clog2(NUM_PREGS); CW = $clog2(DEPTH+1).

Ports:
- clk, in, 1: single clock; all state on rising edge.
- rst, in, 1: asynchronous, active-low reset.
- alloc_req, in, RENAME_WIDTH: lane k needs a new preg this cycle.
- alloc_ready, out, 1: all requested lanes can be granted this cycle.
- alloc_preg, out, RENAME_WIDTH x PW: preg granted to lane k; valid when alloc_req[k] && alloc_ready.
- free_valid, in, COMMIT_WIDTH: lane k returns a stale preg.
- free_preg, in, COMMIT_WIDTH x PW: the preg returned on lane k.
- commit_alloc, in, COMMIT_WIDTH: committing instruction on lane k had allocated a dest; advances the commit head.
- flush, in, 1: squash all speculative allocations.
- free_count, out, CW: current number of free entries (registered).

Behaviour:
- Storage:
  - fifo[DEPTH] of PW bits.
  - Pointers head, tail, chead: each $clog2(DEPTH) bits, wrapping modulo DEPTH (DEPTH need not be a power of 2).
  - count: CW bits.
- Reset (rst low, asynchronous):
  - fifo[i] = NUM_AREGS+i.
  - head = tail = chead = 0.
  - count = DEPTH.
  - free_count = DEPTH; alloc_ready = 1 if DEPTH >= RENAME_WIDTH.
  - The RAT's identity reset mapping must stay consistent with this initial contents.
- Allocation (combinational grant, registered update):
  - nreq = popcount(alloc_req).
  - alloc_ready = (count >= nreq), using the registered count. Freed entries are not allocatable until the next cycle.
  - Grant is all-or-nothing: no partial grants.
  - Lane k receives fifo[head + (number of requesting lanes below k)]; requested lanes are compacted in lane order.
  - Unrequested lanes output fifo[head + their prefix], which is don't-care.
  - On grant (nreq>0 && alloc_ready && !flush): head += nreq.
- Free:
  - Each free_valid lane writes free_preg to fifo[tail + prefix], where prefix counts valid free lanes below k.
  - tail += popcount(free_valid).
  - Frees are always accepted, including during flush.
- Commit head: chead += popcount(commit_alloc) every cycle, including during flush.
- Count update: count_next = count - granted + nfree.
- Flush:
  - head <= chead_next (chead plus this cycle's commit_alloc).
  - count <= DEPTH.
  - Alloc is suppressed in the flush cycle; alloc_ready may be high, but the consumer must ignore it.
  - fifo contents between chead and the old head are untouched, so squashed pregs reappear in their original order.
- Invariants (assertions, simulation only):
  - count + nfree - granted <= DEPTH.
  - popcount(free_valid) <= popcount(commit_alloc) cumulatively, so tail never overtakes chead.
  - Violations are a protocol error; the bench flags them, and the RTL does not guard against them.
- Wrap-around:
  - Multi-lane reads/writes straddling DEPTH-1 to 0 must index modulo DEPTH.
- Latency:
  - alloc_preg is zero-cycle from alloc_req.
  - A freed preg is allocatable one cycle after free_valid.

Decomposition:
- CORE_PKG:
  - Holds NUM_PREGS, NUM_AREGS, RENAME_WIDTH, COMMIT_WIDTH.
  - Holds typedef preg_t (logic [PW-1:0]) and a FL_DEPTH constant.
- One sub-module: fl_lane_prefix.
  - Parameterised on width; takes a valid vector.
  - Outputs per-lane exclusive prefix counts plus the total popcount.
  - Instantiated three times: alloc, free, commit_alloc.
- Modulo-DEPTH pointer add is a package function.

Test Plan:
- Reset then alloc_req=2'b11 -> alloc_ready=1, alloc_preg={32,33}; next cycle free_count=30, then alloc_req=2'b10 -> lane1 gets 34.
- Drain to count=1, then alloc_req=2'b11 -> alloc_ready=0, head unchanged; alloc_req=2'b01 -> granted, preg 63, count=0.
- count=0 with free_valid=2'b11, free_preg={5,9} and alloc_req=2'b01 in the same cycle -> alloc_ready=0; next cycle alloc_preg lane0=5, count=2.
- Wrap: set head=DEPTH-1 with count>=2, then alloc both lanes -> pregs from fifo[31] and fifo[0]; head=1.
- Allocate 6 (pregs 32..37), commit_alloc 2 with free_valid returning {3,4}, then flush -> count=32, head=chead=2; the next allocs return 34,35,36,37, and later 3,4 after wrap.
- Assert rst low mid-allocation (asynchronous) -> count=32, head=tail=chead=0 immediately; first alloc after release returns 32.

Source files
------------

// File: rtl/free_list_pkg.sv
// free_list_pkg: shared core sizing for the rename free list.
//   NUM_PREGS / NUM_AREGS   physical / architectural register counts
//   RENAME_WIDTH            alloc lanes per cycle
//   COMMIT_WIDTH            free / commit lanes per cycle
//   FL_DEPTH                free list capacity (pregs not architecturally mapped)
//   ptr_add                 modulo-FL_DEPTH pointer increment
package free_list_pkg;

  localparam int NUM_PREGS    = 64;
  localparam int NUM_AREGS    = 32;
  localparam int RENAME_WIDTH = 2;
  localparam int COMMIT_WIDTH = 2;

  localparam int FL_DEPTH = NUM_PREGS - NUM_AREGS;
  localparam int PW       = $clog2(NUM_PREGS);
  localparam int CW       = $clog2(FL_DEPTH + 1);
  localparam int PTRW     = $clog2(FL_DEPTH);
  localparam int RCW      = $clog2(RENAME_WIDTH + 1);
  localparam int MCW      = $clog2(COMMIT_WIDTH + 1);

  typedef logic [PW-1:0]   preg_t;
  typedef logic [PTRW-1:0] ptr_t;
  typedef logic [CW-1:0]   cnt_t;

  // Pointer advance modulo FL_DEPTH. inc never exceeds FL_DEPTH, so a single
  // conditional subtract is enough even when FL_DEPTH is not a power of two.
  function automatic ptr_t ptr_add(input ptr_t p, input logic [PTRW:0] inc);
    logic [PTRW+1:0] s;
    s = {2'b00, p} + {1'b0, inc};
    if (s >= (PTRW+2)'(FL_DEPTH))
      s = s - (PTRW+2)'(FL_DEPTH);
    return s[PTRW-1:0];
  endfunction

endpackage

// File: rtl/free_list_lane_prefix.sv
// fl_lane_prefix: per-lane exclusive prefix popcount of a valid vector.
//   vld     lane valid bits
//   prefix  packed per-lane counts: lane k gets the number of set bits below k
//   total   popcount of vld
// Used to compact active lanes onto consecutive FIFO slots.
module fl_lane_prefix #(
  parameter int W    = 2,
  parameter int CNTW = $clog2(W + 1)
) (
  input  logic [W-1:0]      vld,
  output logic [W*CNTW-1:0] prefix,
  output logic [CNTW-1:0]   total
);

  logic [CNTW-1:0] acc;

  always_comb begin
    acc    = '0;
    prefix = '0;
    for (int k = 0; k < W; k++) begin
      prefix[k*CNTW +: CNTW] = acc;
      acc = acc + CNTW'(vld[k]);
    end
    total = acc;
  end

endmodule

// File: rtl/free_list.sv
// free_list: physical-register free list for the rename stage.
// Circular FIFO holding exactly the pregs not mapped by architectural state.
// head: next preg to hand out; tail: where committed stale pregs return;
// chead: head as seen by committed state, so a flush rewinds head in one cycle.
// Ports:
//   clk, rst        clock, asynchronous active-low reset
//   alloc_req       lane k wants a new preg this cycle
//   alloc_ready     all requesting lanes can be granted (from registered count)
//   alloc_preg      per-lane granted preg, packed lane k at [k*PW +: PW]
//   free_valid      lane k returns a stale preg
//   free_preg       per-lane returned preg, packed like alloc_preg
//   commit_alloc    committing lane k had allocated a dest (advances chead)
//   flush           squash all speculative allocations
//   free_count      registered number of free entries
// Reset contents (NUM_AREGS+i) must match the RAT's identity reset mapping.
module free_list
  import free_list_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic [RENAME_WIDTH-1:0]    alloc_req,
  output logic                       alloc_ready,
  output logic [RENAME_WIDTH*PW-1:0] alloc_preg,
  input  logic [COMMIT_WIDTH-1:0]    free_valid,
  input  logic [COMMIT_WIDTH*PW-1:0] free_preg,
  input  logic [COMMIT_WIDTH-1:0]    commit_alloc,
  input  logic                       flush,
  output logic [CW-1:0]              free_count
);

  preg_t fifo [FL_DEPTH];
  ptr_t  head, tail, chead;
  cnt_t  count;

  logic [RENAME_WIDTH*RCW-1:0] apfx;
  logic [RCW-1:0]              nreq;
  logic [COMMIT_WIDTH*MCW-1:0] fpfx;
  logic [MCW-1:0]              nfree;
  logic [COMMIT_WIDTH*MCW-1:0] cpfx_unused;
  logic [MCW-1:0]              ncommit;

  logic  grant;
  cnt_t  granted;
  ptr_t  chead_next;

  fl_lane_prefix #(.W(RENAME_WIDTH), .CNTW(RCW)) u_alloc_pfx (
    .vld    (alloc_req),
    .prefix (apfx),
    .total  (nreq)
  );

  fl_lane_prefix #(.W(COMMIT_WIDTH), .CNTW(MCW)) u_free_pfx (
    .vld    (free_valid),
    .prefix (fpfx),
    .total  (nfree)
  );

  // Only the total matters for the commit head; lane prefixes are left open.
  fl_lane_prefix #(.W(COMMIT_WIDTH), .CNTW(MCW)) u_cmt_pfx (
    .vld    (commit_alloc),
    .prefix (cpfx_unused),
    .total  (ncommit)
  );

  // Readiness uses the registered count only: a preg freed this cycle is
  // not visible to allocation until the next one.
  assign alloc_ready = (count >= CW'(nreq));
  assign grant       = (nreq != '0) && alloc_ready && !flush;
  assign granted     = grant ? CW'(nreq) : '0;
  assign chead_next  = ptr_add(chead, (PTRW+1)'(ncommit));
  assign free_count  = count;

  // Requesting lanes are compacted onto consecutive slots from head.
  // Unrequested lanes still present a value; the consumer ignores it.
  always_comb begin
    alloc_preg = '0;
    for (int k = 0; k < RENAME_WIDTH; k++)
      alloc_preg[k*PW +: PW] = fifo[ptr_add(head, (PTRW+1)'(apfx[k*RCW +: RCW]))];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < FL_DEPTH; i++)
        fifo[i] <= PW'(NUM_AREGS + i);
      head  <= '0;
      tail  <= '0;
      chead <= '0;
      count <= CW'(FL_DEPTH);
    end else begin
      // Frees are accepted unconditionally, flush included.
      for (int k = 0; k < COMMIT_WIDTH; k++)
        if (free_valid[k])
          fifo[ptr_add(tail, (PTRW+1)'(fpfx[k*MCW +: MCW]))] <= free_preg[k*PW +: PW];
      tail  <= ptr_add(tail, (PTRW+1)'(nfree));
      chead <= chead_next;
      if (flush) begin
        // Entries between chead and the old head are untouched, so squashed
        // pregs come back out in their original order. All non-architectural
        // pregs are free again once speculation is gone.
        head  <= chead_next;
        count <= CW'(FL_DEPTH);
      end else begin
        if (grant)
          head <= ptr_add(head, (PTRW+1)'(nreq));
        count <= count - granted + CW'(nfree);
      end
    end
  end

  // Protocol checks: returning more pregs than were ever allocated would
  // overflow the list and let tail run past chead.
  logic [CW:0] cnt_after;
  assign cnt_after = {1'b0, count} + (CW+1)'(nfree) - {1'b0, granted};

  a_count_bound: assert property (@(posedge clk) disable iff (!rst)
    cnt_after <= (CW+1)'(FL_DEPTH));

  a_count_range: assert property (@(posedge clk) disable iff (!rst)
    count <= CW'(FL_DEPTH));

endmodule

// File: tb/tb_free_list.sv
module tb_free_list;
  import free_list_pkg::*;

  logic                       clk = 1'b0;
  logic                       rst = 1'b0;
  logic [RENAME_WIDTH-1:0]    alloc_req = '0;
  logic                       alloc_ready;
  logic [RENAME_WIDTH*PW-1:0] alloc_preg;
  logic [COMMIT_WIDTH-1:0]    free_valid = '0;
  logic [COMMIT_WIDTH*PW-1:0] free_preg = '0;
  logic [COMMIT_WIDTH-1:0]    commit_alloc = '0;
  logic                       flush = 1'b0;
  logic [CW-1:0]              free_count;

  free_list dut (
    .clk          (clk),
    .rst          (rst),
    .alloc_req    (alloc_req),
    .alloc_ready  (alloc_ready),
    .alloc_preg   (alloc_preg),
    .free_valid   (free_valid),
    .free_preg    (free_preg),
    .commit_alloc (commit_alloc),
    .flush        (flush),
    .free_count   (free_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: avail = free pregs in hand-out order,
  // spec = pregs handed out but not yet committed (oldest first).
  int avail[$];
  int spec[$];

  typedef struct {
    logic                              ready;
    logic                              chk_preg;
    logic [RENAME_WIDTH-1:0]           req;
    logic [RENAME_WIDTH-1:0][PW-1:0]   p;
    int                                fc;
  } exp_t;

  exp_t exp_q[$];

  task automatic model_reset();
    avail.delete();
    spec.delete();
    for (int i = 0; i < FL_DEPTH; i++) avail.push_back(NUM_AREGS + i);
  endtask

  // One cycle of stimulus: drive inputs just after the edge, record what the
  // DUT must show this cycle, then advance the model past the next edge.
  task automatic drive(input logic [1:0] req, input logic [1:0] fv, input int fp0,
                       input int fp1, input logic [1:0] ca, input logic fl);
    exp_t e;
    int   idx;
    int   fp[2];
    @(posedge clk); #1;
    alloc_req    = req;
    free_valid   = fv;
    free_preg    = {PW'(fp1), PW'(fp0)};
    commit_alloc = ca;
    flush        = fl;
    fp[0] = fp0; fp[1] = fp1;

    e.req      = req;
    e.fc       = avail.size();
    e.ready    = (avail.size() >= $countones(req));
    e.chk_preg = e.ready && !fl;
    idx = 0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      e.p[k] = '0;
      if (req[k]) begin
        e.p[k] = PW'(avail[idx]);
        idx++;
      end
    end
    exp_q.push_back(e);

    if (e.chk_preg)
      for (int k = 0; k < RENAME_WIDTH; k++)
        if (req[k]) spec.push_back(avail.pop_front());
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (ca[k]) void'(spec.pop_front());
    for (int k = 0; k < COMMIT_WIDTH; k++)
      if (fv[k]) avail.push_back(fp[k]);
    if (fl) begin
      avail = {spec, avail};
      spec.delete();
    end
  endtask

  // Monitor: outputs are presented every cycle; compare at mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("alloc_ready", 32'(alloc_ready), 32'(e.ready));
        check("free_count", 32'(free_count), 32'(e.fc));
        if (e.chk_preg)
          for (int k = 0; k < RENAME_WIDTH; k++)
            if (e.req[k])
              check($sformatf("alloc_preg_lane%0d", k), 32'(alloc_preg[k*PW +: PW]), 32'(e.p[k]));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] r, c;
    model_reset();
    #12;
    check("reset_free_count", 32'(free_count), 32'(FL_DEPTH));
    check("reset_alloc_ready", 32'(alloc_ready), 32'd1);
    rst = 1'b1;

    // Basic two-lane grant, then single lane 1 compacted to slot 0.
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("first_lane0", 32'(alloc_preg[0 +: PW]), 32'd32);
    check("first_lane1", 32'(alloc_preg[PW +: PW]), 32'd33);
    drive(2'b10, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("second_count", 32'(free_count), 32'd30);
    check("second_lane1", 32'(alloc_preg[PW +: PW]), 32'd34);

    // Drain down to one free entry; no partial grant.
    repeat (14) drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("count1_pair_ready", 32'(alloc_ready), 32'd0);
    drive(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("count1_single", 32'(alloc_preg[0 +: PW]), 32'd63);

    // Empty: frees this cycle are not allocatable until the next.
    drive(2'b01, 2'b11, 5, 9, 2'b11, 1'b0); #1;
    check("empty_ready", 32'(alloc_ready), 32'd0);
    drive(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("refill_lane0", 32'(alloc_preg[0 +: PW]), 32'd5);
    check("refill_count", 32'(free_count), 32'd2);

    // Asynchronous reset mid-cycle while allocating.
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    #2;
    exp_q.delete();
    rst = 1'b0;
    #1;
    check("async_rst_count", 32'(free_count), 32'(FL_DEPTH));
    check("async_rst_lane0", 32'(alloc_preg[0 +: PW]), 32'd32);
    model_reset();
    alloc_req = '0;
    #3 rst = 1'b1;

    // Flush rewinds to the commit head; then wrap across the FIFO end.
    repeat (3) drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    drive(2'b00, 2'b11, 3, 4, 2'b11, 1'b0);
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b1);
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("flush_count", 32'(free_count), 32'(FL_DEPTH));
    check("flush_lane0", 32'(alloc_preg[0 +: PW]), 32'd34);
    check("flush_lane1", 32'(alloc_preg[PW +: PW]), 32'd35);
    drive(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("flush_next", 32'(alloc_preg[0 +: PW]), 32'd36);
    repeat (13) drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0);
    drive(2'b11, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("wrap_lane0", 32'(alloc_preg[0 +: PW]), 32'd63);
    check("wrap_lane1", 32'(alloc_preg[PW +: PW]), 32'd3);
    drive(2'b01, 2'b00, 0, 0, 2'b00, 1'b0); #1;
    check("wrap_after", 32'(alloc_preg[0 +: PW]), 32'd4);

    // Randomized traffic; commits never exceed outstanding allocations and
    // every commit returns one stale preg.
    for (int i = 0; i < 2000; i++) begin
      r = 2'($urandom_range(0, 3));
      c = 2'($urandom_range(0, 3));
      if (spec.size() == 0) c = 2'b00;
      else if (spec.size() == 1 && c == 2'b11) c = 2'b01;
      drive(r, c, int'($urandom_range(0, NUM_PREGS-1)), int'($urandom_range(0, NUM_PREGS-1)),
            c, ($urandom_range(0, 19) == 0));
    end
    drive(2'b00, 2'b00, 0, 0, 2'b00, 1'b0);
    repeat (2) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
